// File: rtl/iterative_alu_if.sv
// rtl/iterative_alu_if.sv - request/response bundle between operand select, the iterative ALU and writeback
//
// Signals:
//   in_valid/in_ready      request handshake (upstream -> ALU)
//   aluControl, isShamt    operation code and shift-datapath select
//   srcA, srcB             operands; srcB low $clog2(WIDTH) bits are the shift amount
//   out_valid/out_ready    response handshake (ALU -> downstream)
//   result, zero           registered result and its zero flag
//   busy                   ALU is not idle
// Modports: master = upstream/downstream side, slave = the ALU.
interface iterative_alu_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       aluControl;
  logic             isShamt;
  logic [WIDTH-1:0] srcA;
  logic [WIDTH-1:0] srcB;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             busy;

  modport master (
    output in_valid, aluControl, isShamt, srcA, srcB, out_ready,
    input  in_ready, out_valid, result, zero, busy
  );

  modport slave (
    input  in_valid, aluControl, isShamt, srcA, srcB, out_ready,
    output in_ready, out_valid, result, zero, busy
  );
endinterface

// File: rtl/iterative_alu.sv
// rtl/iterative_alu.sv - execute-stage ALU with single-cycle arith/logic and bit-serial shifts
//
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-high reset, returns to IDLE and clears result
//   bus    iterative_alu_if.slave: request (in_valid/in_ready, aluControl, isShamt,
//          srcA, srcB), response (out_valid/out_ready, result, zero), busy
module iterative_alu #(
  parameter int WIDTH = 32
) (
  input  logic            clk,
  input  logic            reset,
  iterative_alu_if.slave  bus
);
  localparam int SW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] acc, acc_n;
  logic [WIDTH-1:0] result_q, result_n;
  logic [SW-1:0]    cnt, cnt_n;
  logic [3:0]       op, op_n;

  logic [WIDTH-1:0] alu_out;
  logic [WIDTH-1:0] shift_out;
  logic [SW-1:0]    shamt;
  logic             is_shift_code;

  assign shamt         = bus.srcB[SW-1:0];
  assign is_shift_code = (bus.aluControl == 4'd2) || (bus.aluControl == 4'd6) ||
                         (bus.aluControl == 4'd7);

  // Single-cycle datapath. Shift codes land in the default arm: shifting is
  // only done by the iterative path, selected with isShamt.
  always_comb begin
    alu_out = '0;
    unique case (bus.aluControl)
      4'd0:    alu_out = bus.srcA + bus.srcB;
      4'd1:    alu_out = bus.srcA - bus.srcB;
      4'd3:    alu_out = {{(WIDTH-1){1'b0}}, ($signed(bus.srcA) < $signed(bus.srcB))};
      4'd4:    alu_out = {{(WIDTH-1){1'b0}}, (bus.srcA < bus.srcB)};
      4'd5:    alu_out = bus.srcA ^ bus.srcB;
      4'd8:    alu_out = bus.srcA | bus.srcB;
      4'd9:    alu_out = bus.srcA & bus.srcB;
      default: alu_out = '0;
    endcase
  end

  // One-bit shift step; op only ever holds 2, 6 or 7 while in SHIFT.
  always_comb begin
    shift_out = '0;
    unique case (op)
      4'd2:    shift_out = {acc[WIDTH-2:0], 1'b0};
      4'd6:    shift_out = {acc[WIDTH-1], acc[WIDTH-1:1]};
      default: shift_out = {1'b0, acc[WIDTH-1:1]};
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n  = state;
    acc_n    = acc;
    cnt_n    = cnt;
    op_n     = op;
    result_n = result_q;
    unique case (state)
      IDLE: begin
        if (bus.in_valid) begin
          op_n = bus.aluControl;
          if (!bus.isShamt) begin
            result_n = alu_out;
            state_n  = DONE;
          end else if (is_shift_code && (shamt == '0)) begin
            result_n = bus.srcA;
            state_n  = DONE;
          end else if (is_shift_code) begin
            acc_n   = bus.srcA;
            cnt_n   = shamt;
            state_n = SHIFT;
          end else begin
            result_n = '0;
            state_n  = DONE;
          end
        end
      end
      SHIFT: begin
        // The last step goes straight into result so acc never needs a final copy.
        if (cnt == SW'(1)) begin
          result_n = shift_out;
          state_n  = DONE;
        end else begin
          acc_n = shift_out;
          cnt_n = cnt - SW'(1);
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc      <= '0;
      cnt      <= '0;
      op       <= '0;
      result_q <= '0;
    end else begin
      acc      <= acc_n;
      cnt      <= cnt_n;
      op       <= op_n;
      result_q <= result_n;
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.busy      = (state != IDLE);
  assign bus.result    = result_q;
  assign bus.zero      = (result_q == '0);
endmodule
